// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg
//   Shared definitions for the bit-serial ALU sequencer and its 1-bit cell.
//   Contents:
//     - ALU_* opcode encodings (3 bits)
//     - sequencer state type (SACTL_IDLE/RUN/DONE, 2 bits)
//     - helpers that map a multi-bit opcode onto the cell
package serial_alu_ctrl_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_ADDC = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;

    typedef enum logic [1:0] {
        SACTL_IDLE = 2'd0,
        SACTL_RUN  = 2'd1,
        SACTL_DONE = 2'd2
    } sactl_state_e;

    // Operations that ripple a carry from bit to bit.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_ADDC);
    endfunction

    // Multi-bit ADD/SUB/ADDC all run on the cell's full-adder op;
    // everything else is passed straight through.
    function automatic logic [2:0] cell_op(input logic [2:0] op);
        return is_arith(op) ? ALU_ADDC : op;
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_alu.sv
// alu
//   1-bit ALU cell used as the datapath of serial_alu_ctrl.
//   Ports:
//     op   in  3  operation (ALU_*)
//     a    in  1  operand bit A
//     b    in  1  operand bit B
//     cin  in  1  carry in (used by ALU_ADDC)
//     y    out 1  result bit
//     cout out 1  carry out (ALU_ADD/ALU_ADDC), borrow out (ALU_SUB)
//   Undefined opcodes give y=0, cout=0.
module alu
    import serial_alu_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       y,
    output logic       cout
);

    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        case (op)
            ALU_ADD: begin
                y    = a ^ b;
                cout = a & b;
            end
            ALU_SUB: begin
                y    = a ^ b;
                cout = ~a & b;
            end
            ALU_ADDC: begin
                y    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            default: begin
                y    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl
//   Bit-serial sequencer driving the 1-bit alu cell over WIDTH-bit operands,
//   one bit per clock, LSB first. Carry is held in a flop between bits.
//   Parameters:
//     WIDTH  operand/result width (>= 2)
//     CNT_W  bit counter width, derived
//   Ports:
//     clk     in   1      system clock, rising edge
//     rst     in   1      asynchronous active-high reset
//     start   in   1      request, accepted only when ready=1
//     opcode  in   3      ALU_* operation
//     op_a    in   WIDTH  operand A, sampled on accepted start
//     op_b    in   WIDTH  operand B, sampled on accepted start
//     ready   out  1      idle, can accept start
//     done    out  1      one-cycle pulse, result/cout valid
//     result  out  WIDTH  result, held until next accepted start
//     cout    out  1      carry / no-borrow flag (0 for logic ops)
//     zero    out  1      result==0 flag (only with SERIAL_ALU_ZERO_FLAG_EN)
//   Optional feature macro: SERIAL_ALU_ZERO_FLAG_EN
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    sactl_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             any_one;
`endif

    logic cell_b;
    logic cell_y;
    logic cell_co;
    logic last_bit;

    // SUB is A + ~B + 1: invert B here, the +1 comes from the carry preload.
    assign cell_b   = (op_q == ALU_SUB) ? ~b_sr[0] : b_sr[0];
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    alu u_alu (
        .op   (cell_op(op_q)),
        .a    (a_sr[0]),
        .b    (cell_b),
        .cin  (carry),
        .y    (cell_y),
        .cout (cell_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SACTL_IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            op_q    <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            any_one <= 1'b0;
            zero    <= 1'b0;
`endif
        end else begin
            case (state)
                SACTL_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= opcode;
                        a_sr    <= op_a;
                        b_sr    <= op_b;
                        result  <= '0;
                        cnt     <= '0;
                        carry   <= (opcode == ALU_SUB);
                        cout    <= 1'b0;
                        ready   <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                        any_one <= 1'b0;
                        zero    <= 1'b0;
`endif
                        state   <= SACTL_RUN;
                    end
                end
                SACTL_RUN: begin
                    // Operands shift right so bit i is always at index 0;
                    // result fills from the MSB so bit i lands at index i.
                    result <= {cell_y, result[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (is_arith(op_q)) begin
                        carry <= cell_co;
                    end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    any_one <= any_one | cell_y;
`endif
                    if (last_bit) begin
                        cout  <= is_arith(op_q) ? cell_co : 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                        zero  <= ~(any_one | cell_y);
`endif
                        done  <= 1'b1;
                        state <= SACTL_DONE;
                    end
                end
                SACTL_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= SACTL_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= SACTL_IDLE;
                end
            endcase
        end
    end

endmodule
